// File: rtl/counter_checker_if.sv
// Observed-count stream into the checker and its status back out.
// master drives valid/data; slave (the checker) drives the status signals.
interface counter_checker_if #(
    parameter int WIDTH     = 64,
    parameter int ERR_WIDTH = 16
);
    logic                 valid;
    logic [WIDTH-1:0]     data;
    logic                 locked;
    logic                 error;
    logic [ERR_WIDTH-1:0] err_count;
    logic [WIDTH-1:0]     expected;

    modport master (
        output valid, data,
        input  locked, error, err_count, expected
    );

    modport slave (
        input  valid, data,
        output locked, error, err_count, expected
    );
endinterface

// File: rtl/counter_checker.sv
// Locks to an incrementing count stream and flags every sample that is not previous+1.
// Latency: sample registered at edge k, compared and reflected on outputs at edge k+1.
// Backpressure: none; every valid sample is accepted, gaps in valid are ignored.
module counter_checker #(
    parameter int WIDTH        = 64,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2,
    parameter int ERR_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    counter_checker_if.slave  bus
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    logic [1:0] rst_sync_q;
    logic       rst_int;

    logic                 v_q;
    logic [WIDTH-1:0]     d_q;
    state_e               state_q, state_d;
    logic [MW-1:0]        match_q, match_d;
    logic [UW-1:0]        miss_q, miss_d;
    logic                 have_prev_q, have_prev_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 error_q, error_d;

    logic [WIDTH-1:0]     next_val;
    logic                 hit;

    // Assert immediately, release on the second clk edge after reset_in falls.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            v_q         <= 1'b0;
            d_q         <= '0;
            state_q     <= SEARCH;
            match_q     <= '0;
            miss_q      <= '0;
            have_prev_q <= 1'b0;
            expected_q  <= '0;
            err_cnt_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            v_q         <= bus.valid;
            d_q         <= bus.data;
            state_q     <= state_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            have_prev_q <= have_prev_d;
            expected_q  <= expected_d;
            err_cnt_q   <= err_cnt_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        miss_d      = miss_q;
        have_prev_d = have_prev_q;
        expected_d  = expected_q;
        err_cnt_d   = err_cnt_q;
        error_d     = 1'b0;
        next_val    = d_q + WIDTH'(1);
        hit         = (d_q == expected_q);

        if (v_q) begin
            // Always resync the prediction to the observed value.
            expected_d = next_val;
            case (state_q)
                SEARCH: begin
                    if (!have_prev_q) begin
                        have_prev_d = 1'b1;
                    end else if (hit) begin
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
                        end
                        if (miss_q == UW'(UNLOCK_COUNT - 1)) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                            match_d = '0;
                        end else begin
                            miss_d = miss_q + UW'(1);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.error     = error_q;
    assign bus.err_count = err_cnt_q;
    assign bus.expected  = expected_q;
endmodule
